// File: rtl/rv_multicycle_controller_if.sv
// Unified memory-port handshake between the multicycle controller and the memory
// subsystem. The controller drives the request; memory returns the ready strobe.
interface rv_multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_we, input adr_src, output mem_ready);
endinterface

// File: rtl/rv_multicycle_controller.sv
// Multicycle RV32I control FSM sharing one ALU and one req/ready memory port.
// Define RV_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes and expose illegal_instr.
module rv_multicycle_controller #(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned IMM_SEL_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  rv_multicycle_controller_if.master mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [IMM_SEL_W-1:0]  imm_sel,
  output logic                  instr_retire
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                  illegal_instr
`endif
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] Funct7Alt = 7'b0100000;

  localparam logic [1:0] SrcAPc    = 2'd0;
  localparam logic [1:0] SrcAOldPc = 2'd1;
  localparam logic [1:0] SrcARs1   = 2'd2;
  localparam logic [1:0] SrcAZero  = 2'd3;
  localparam logic [1:0] SrcBRs2   = 2'd0;
  localparam logic [1:0] SrcBImm   = 2'd1;
  localparam logic [1:0] SrcBFour  = 2'd2;
  localparam logic [1:0] ResAluOut = 2'd0;
  localparam logic [1:0] ResMem    = 2'd1;
  localparam logic [1:0] ResAlu    = 2'd2;

  localparam logic [ALU_CTRL_W-1:0] AluAdd  = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] AluSub  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] AluAnd  = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] AluOr   = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] AluSlt  = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] AluXor  = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] AluSll  = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] AluSrl  = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] AluSra  = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] AluSltu = ALU_CTRL_W'(9);

  localparam logic [IMM_SEL_W-1:0] ImmI = IMM_SEL_W'(0);
  localparam logic [IMM_SEL_W-1:0] ImmS = IMM_SEL_W'(1);
  localparam logic [IMM_SEL_W-1:0] ImmB = IMM_SEL_W'(2);
  localparam logic [IMM_SEL_W-1:0] ImmJ = IMM_SEL_W'(3);
  localparam logic [IMM_SEL_W-1:0] ImmU = IMM_SEL_W'(4);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExecR, StExecI,
    StAluWb, StBranch, StJal, StJalPc, StJalr, StJalrPc, StLui, StTrap
  } state_e;

  state_e state_q, state_d;

  logic [ALU_CTRL_W-1:0] alu_op;
  logic                  taken;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // funct7 only selects sub for R-type, but selects sra for both R and I shifts.
  always_comb begin
    alu_op = AluAdd;
    unique case (funct3)
      3'b000: alu_op = (state_q == StExecR && funct7 == Funct7Alt) ? AluSub : AluAdd;
      3'b001: alu_op = AluSll;
      3'b010: alu_op = AluSlt;
      3'b011: alu_op = AluSltu;
      3'b100: alu_op = AluXor;
      3'b101: alu_op = (funct7 == Funct7Alt) ? AluSra : AluSrl;
      3'b110: alu_op = AluOr;
      3'b111: alu_op = AluAnd;
      default: alu_op = AluAdd;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.adr_src  = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = SrcAPc;
    alu_src_b    = SrcBRs2;
    result_src   = ResAluOut;
    alu_control  = AluAdd;
    imm_sel      = ImmI;
    instr_retire = 1'b0;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    // Outputs stay quiet throughout reset so an abandoned instruction cannot commit.
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_a  = SrcAPc;
            alu_src_b  = SrcBFour;
            result_src = ResAlu;
            state_d    = StDecode;
          end
        end
        StDecode: begin
          alu_src_a = SrcAOldPc;
          alu_src_b = SrcBImm;
          imm_sel   = ImmB;
          case (opcode)
            OpLoad, OpStore: state_d = StMemAdr;
            OpReg:           state_d = StExecR;
            OpImm:           state_d = StExecI;
            OpBranch:        state_d = StBranch;
            OpJal:           state_d = StJal;
            OpJalr:          state_d = StJalr;
            OpLui, OpAuipc:  state_d = StLui;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
            default:         state_d = StTrap;
`else
            default:         state_d = StFetch;
`endif
          endcase
        end
        StMemAdr: begin
          alu_src_a = SrcARs1;
          alu_src_b = SrcBImm;
          imm_sel   = (opcode == OpStore) ? ImmS : ImmI;
          state_d   = (opcode == OpStore) ? StMemWr : StMemRd;
        end
        StMemRd: begin
          mem.mem_req = 1'b1;
          mem.adr_src = 1'b1;
          if (mem.mem_ready) state_d = StMemWb;
        end
        StMemWb: begin
          result_src   = ResMem;
          reg_write    = 1'b1;
          instr_retire = 1'b1;
          state_d      = StFetch;
        end
        StMemWr: begin
          mem.mem_req = 1'b1;
          mem.mem_we  = 1'b1;
          mem.adr_src = 1'b1;
          if (mem.mem_ready) begin
            instr_retire = 1'b1;
            state_d      = StFetch;
          end
        end
        StExecR, StExecI: begin
          alu_src_a   = SrcARs1;
          alu_src_b   = (state_q == StExecI) ? SrcBImm : SrcBRs2;
          alu_control = alu_op;
          state_d     = StAluWb;
        end
        StAluWb: begin
          reg_write    = 1'b1;
          instr_retire = 1'b1;
          state_d      = StFetch;
        end
        StBranch: begin
          alu_src_a    = SrcARs1;
          alu_control  = AluSub;
          pc_write     = taken;
          instr_retire = 1'b1;
          state_d      = StFetch;
        end
        StJal, StJalr: begin
          // Link cycle: rd <= old_pc + 4.
          alu_src_a  = SrcAOldPc;
          alu_src_b  = SrcBFour;
          result_src = ResAlu;
          reg_write  = 1'b1;
          state_d    = (state_q == StJal) ? StJalPc : StJalrPc;
        end
        StJalPc, StJalrPc: begin
          pc_write     = 1'b1;
          result_src   = ResAlu;
          alu_src_a    = (state_q == StJalPc) ? SrcAOldPc : SrcARs1;
          alu_src_b    = SrcBImm;
          imm_sel      = (state_q == StJalPc) ? ImmJ : ImmI;
          instr_retire = 1'b1;
          state_d      = StFetch;
        end
        StLui: begin
          imm_sel      = ImmU;
          alu_src_a    = (opcode == OpLui) ? SrcAZero : SrcAOldPc;
          alu_src_b    = SrcBImm;
          result_src   = ResAlu;
          reg_write    = 1'b1;
          instr_retire = 1'b1;
          state_d      = StFetch;
        end
        StTrap: begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
          illegal_instr = 1'b1;
`endif
          state_d = StTrap;
        end
        default: state_d = StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_controller.sv
// Directed cycle-by-cycle check of the multicycle controller's control vector
// against hand-computed expectations for each instruction class.
module tb_rv_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_zero, alu_lt, alu_ltu;
  logic       ir_write, pc_write, reg_write, instr_retire;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_control;
  logic [2:0] imm_sel;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rv_multicycle_controller_if mem_if ();

  rv_multicycle_controller #(.ALU_CTRL_W(4), .IMM_SEL_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .alu_zero     (alu_zero),
    .alu_lt       (alu_lt),
    .alu_ltu      (alu_ltu),
    .mem          (mem_if),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .result_src   (result_src),
    .alu_control  (alu_control),
    .imm_sel      (imm_sel),
    .instr_retire (instr_retire)
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_instr(illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {mem_if.mem_req, mem_if.mem_we, mem_if.adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_control, imm_sel, instr_retire};

  function automatic logic [19:0] v(input logic req, input logic we, input logic adr,
                                    input logic irw, input logic pcw, input logic rw,
                                    input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] rs, input logic [3:0] alu,
                                    input logic [2:0] imm, input logic ret);
    return {req, we, adr, irw, pcw, rw, a, b, rs, alu, imm, ret};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Check the settled control vector of the current state, then advance one clock.
  task automatic cyc(input string tag, input logic [19:0] exp);
    #1;
    check(tag, 32'(obs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  logic [19:0] v_fetch, v_fetch_wait, v_decode, v_aluwb, v_link;

  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [3:0] exp_alu);
    set_instr(op, f3, f7);
    cyc({tag, "_fetch"}, v_fetch);
    cyc({tag, "_decode"}, v_decode);
    cyc({tag, "_exec"}, v(0, 0, 0, 0, 0, 0, 2'd2, (op == 7'b0010011) ? 2'd1 : 2'd0, 2'd0,
                          exp_alu, 3'd0, 0));
    cyc({tag, "_wb"}, v_aluwb);
  endtask

  task automatic run_br(input string tag, input logic [2:0] f3, input logic z, input logic lt,
                        input logic ltu, input logic tk);
    set_instr(7'b1100011, f3, 7'd0);
    alu_zero = z;
    alu_lt   = lt;
    alu_ltu  = ltu;
    cyc({tag, "_fetch"}, v_fetch);
    cyc({tag, "_decode"}, v_decode);
    cyc({tag, "_branch"}, v(0, 0, 0, 0, tk, 0, 2'd2, 2'd0, 2'd0, 4'd1, 3'd0, 1));
  endtask

  logic [3:0] r_exp [8];

  initial begin
    v_fetch      = v(1, 0, 0, 1, 1, 0, 2'd0, 2'd2, 2'd2, 4'd0, 3'd0, 0);
    v_fetch_wait = v(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0, 0);
    v_decode     = v(0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 4'd0, 3'd2, 0);
    v_aluwb      = v(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0, 1);
    v_link       = v(0, 0, 0, 0, 0, 1, 2'd1, 2'd2, 2'd2, 4'd0, 3'd0, 0);
    // R-type funct3 0..7 with funct7 = 0100000 on f3=000 only.
    r_exp = '{4'd1, 4'd6, 4'd4, 4'd9, 4'd5, 4'd7, 4'd3, 4'd2};

    rst_n = 1'b0;
    mem_if.mem_ready = 1'b1;
    alu_zero = 1'b0;
    alu_lt   = 1'b0;
    alu_ltu  = 1'b0;
    set_instr(7'b0110011, 3'd0, 7'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(obs), 32'd0);
    rst_n = 1'b1;
    mem_if.mem_ready = 1'b0;
    cyc("fetch_wait", v_fetch_wait);
    mem_if.mem_ready = 1'b1;

    run_alu("add", 7'b0110011, 3'd0, 7'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      run_alu("rtype", 7'b0110011, 3'(i), (i == 0) ? 7'b0100000 : 7'd0, r_exp[i]);
    end
    run_alu("sra",  7'b0110011, 3'd5, 7'b0100000, 4'd8);
    run_alu("srai", 7'b0010011, 3'd5, 7'b0100000, 4'd8);
    run_alu("addi_f7", 7'b0010011, 3'd0, 7'b0100000, 4'd0);
    run_alu("srli", 7'b0010011, 3'd5, 7'd0, 4'd7);
    run_alu("sltiu", 7'b0010011, 3'd3, 7'd0, 4'd9);

    // lw with three memory wait states
    set_instr(7'b0000011, 3'd2, 7'd0);
    cyc("lw_fetch", v_fetch);
    cyc("lw_decode", v_decode);
    cyc("lw_memadr", v(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 4'd0, 3'd0, 0));
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", v(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    mem_if.mem_ready = 1'b1;
    cyc("lw_memrd", v(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw_memwb", v(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd1, 4'd0, 3'd0, 1));

    set_instr(7'b0100011, 3'd2, 7'd0);
    cyc("sw_fetch", v_fetch);
    cyc("sw_decode", v_decode);
    cyc("sw_memadr", v(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 4'd0, 3'd1, 0));
    cyc("sw_memwr", v(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc("sw_next_fetch", v_fetch);

    // after sw the FSM is back in DECODE; finish with a branch from FETCH
    set_instr(7'b1100011, 3'd1, 7'd0);
    cyc("br_pre_decode", v_decode);
    cyc("br_pre_branch", v(0, 0, 0, 0, 1, 0, 2'd2, 2'd0, 2'd0, 4'd1, 3'd0, 1));
    run_br("bne_nz", 3'd1, 0, 0, 0, 1);
    run_br("beq_nz", 3'd0, 0, 0, 0, 0);
    run_br("bltu",   3'd6, 0, 0, 1, 1);
    run_br("bge_lt", 3'd5, 0, 1, 0, 0);
    run_br("f3_010", 3'd2, 1, 1, 1, 0);

    set_instr(7'b1101111, 3'd0, 7'd0);
    cyc("jal_fetch", v_fetch);
    cyc("jal_decode", v_decode);
    cyc("jal_link", v_link);
    cyc("jal_pc", v(0, 0, 0, 0, 1, 0, 2'd1, 2'd1, 2'd2, 4'd0, 3'd3, 1));

    set_instr(7'b1100111, 3'd0, 7'd0);
    cyc("jalr_fetch", v_fetch);
    cyc("jalr_decode", v_decode);
    cyc("jalr_link", v_link);
    cyc("jalr_pc", v(0, 0, 0, 0, 1, 0, 2'd2, 2'd1, 2'd2, 4'd0, 3'd0, 1));

    set_instr(7'b0110111, 3'd0, 7'd0);
    cyc("lui_fetch", v_fetch);
    cyc("lui_decode", v_decode);
    cyc("lui", v(0, 0, 0, 0, 0, 1, 2'd3, 2'd1, 2'd2, 4'd0, 3'd4, 1));
    set_instr(7'b0010111, 3'd0, 7'd0);
    cyc("auipc_fetch", v_fetch);
    cyc("auipc_decode", v_decode);
    cyc("auipc", v(0, 0, 0, 0, 0, 1, 2'd1, 2'd1, 2'd2, 4'd0, 3'd4, 1));

    // reset arriving in MEMWR with mem_ready high must abandon the store
    set_instr(7'b0100011, 3'd2, 7'd0);
    cyc("rsw_fetch", v_fetch);
    cyc("rsw_decode", v_decode);
    cyc("rsw_memadr", v(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 4'd0, 3'd1, 0));
    rst_n = 1'b0;
    #1;
    check("rsw_reset_outputs", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_if.mem_ready = 1'b0;
    cyc("rsw_after_fetch", v_fetch_wait);
    mem_if.mem_ready = 1'b1;

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    set_instr(7'b1111111, 3'd0, 7'd0);
    cyc("trap_fetch", v_fetch);
    cyc("trap_decode", v_decode);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("trap_illegal", 32'(illegal_instr), 32'd1);
      cyc("trap_outputs", 20'd0);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("trap_cleared", 32'(illegal_instr), 32'd0);
    cyc("trap_reset_fetch", v_fetch);
`else
    set_instr(7'b1111111, 3'd0, 7'd0);
    cyc("unk_fetch", v_fetch);
    cyc("unk_decode", v_decode);
    cyc("unk_back_fetch", v_fetch);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_controller.md
Name: rv_multicycle_controller

Overview:
- Next-generation control unit for the RV32I core.
- Replaces single-cycle opcode decode with a multi-cycle FSM sharing one ALU and one unified memory port.
- Memory port uses a req/ready handshake so instruction and data accesses can stall.
- Decodes the full RV32I integer ALU set, including I-type arithmetic, shifts, slt/sltu, all six branches, jal, jalr, lui and auipc.

Parameters:
- ALU_CTRL_W, 4, width of alu_control; must be ≥ 4.
- IMM_SEL_W, 3, width of imm_sel; must be ≥ 3.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- alu_zero  in  1  ALU result == 0
- alu_lt  in  1  signed rs1 < rs2 (datapath comparator)
- alu_ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  request is a write
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address
- ir_write  out  1  load instruction register and old_pc
- pc_write  out  1  update PC from result mux
- reg_write  out  1  register file write enable
- alu_src_a  out  2  0 = PC, 1 = old_pc, 2 = rs1, 3 = zero
- alu_src_b  out  2  0 = rs2, 1 = immediate, 2 = constant 4
- result_src  out  2  0 = ALUOut, 1 = mem read data, 2 = ALU result (unregistered)
- alu_control  out  ALU_CTRL_W  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 xor, 6 sll, 7 srl, 8 sra, 9 sltu
- imm_sel  out  IMM_SEL_W  0 I, 1 S, 2 B, 3 J, 4 U
- instr_retire  out  1  one-cycle pulse in the final cycle of each instruction

Behaviour:
- All outputs are Moore or state+opcode combinational. Default value of every output is 0 in every state unless listed.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, LUI, TRAP.
- Reset: when rst_n = 0 at a clk edge, state goes to FETCH. During reset all outputs are 0, including mem_req. Reset applied mid-instruction abandons it; no reg_write or pc_write occurs in the reset cycle.
- FETCH:
  - mem_req = 1, adr_src = 0.
  - Hold until mem_ready.
  - On mem_ready: ir_write = 1, alu_src_a = 0, alu_src_b = 2, add, result_src = 2, pc_write = 1, then go to DECODE.
  - mem_req stays high, with address stable, every waiting cycle.
- DECODE:
  - alu_src_a = 1, alu_src_b = 1, imm_sel = 2, add (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111 or 0010111 → LUI; otherwise → FETCH (or TRAP, see Optional Feature).
- MEMADR:
  - alu_src_a = 2, alu_src_b = 1, add.
  - imm_sel = 0 for load, 1 for store.
  - Next state MEMRD (load) or MEMWR (store).
- MEMRD:
  - mem_req = 1, adr_src = 1.
  - Wait for mem_ready, then go to MEMWB.
- MEMWB:
  - result_src = 1, reg_write = 1, instr_retire = 1, then go to FETCH.
- MEMWR:
  - mem_req = 1, mem_we = 1, adr_src = 1.
  - On mem_ready: instr_retire = 1, then go to FETCH.
- EXEC_R / EXEC_I:
  - alu_src_a = 2.
  - alu_src_b = 0 (R) or 1 with imm_sel = 0 (I).
  - Next state ALUWB.
- ALU decode from funct3:
  - 000: add; sub only when R-type and funct7 = 0100000.
  - 001: sll. 010: slt. 011: sltu. 100: xor.
  - 101: srl, or sra when funct7 = 0100000 (applies to both R and I).
  - 110: or. 111: and.
  - funct7 is ignored for I-type except for 101.
- ALUWB:
  - result_src = 0, reg_write = 1, instr_retire = 1, then go to FETCH.
- BRANCH:
  - alu_src_a = 2, alu_src_b = 0, sub, result_src = 0.
  - pc_write = taken, where taken by funct3: 000 alu_zero, 001 !alu_zero, 100 alu_lt, 101 !alu_lt, 110 alu_ltu, 111 !alu_ltu.
  - funct3 010/011 is never taken.
  - instr_retire = 1, then go to FETCH.
- JAL:
  - alu_src_a = 1, alu_src_b = 2, add, result_src = 2, reg_write = 1 (rd = old_pc + 4).
  - Next state ALUWB-equivalent: JAL proceeds to a second cycle in JALR-style sequence; see below.
- JAL and JALR are two-cycle:
  - First cycle (JAL/JALR) writes the link register as above.
  - Second cycle asserts pc_write = 1, result_src = 2, add, with:
    - JAL: alu_src_a = 1, alu_src_b = 1, imm_sel = 3.
    - JALR: alu_src_a = 2, alu_src_b = 1, imm_sel = 0.
  - The datapath clears bit 0 for JALR.
  - The second cycle asserts instr_retire, then goes to FETCH.
- LUI:
  - imm_sel = 4, alu_src_b = 1, add, result_src = 2, reg_write = 1, instr_retire = 1, then go to FETCH.
  - alu_src_a = 3 for opcode 0110111, 1 for 0010111.
- Simultaneous events: mem_ready while mem_req = 0 is ignored. mem_ready is only sampled in FETCH, MEMRD and MEMWR.
- Branch latency is 3 cycles, R/I-type 4, load 5 (plus wait states), store 4 (plus wait states), jal/jalr 4.

Optional Feature:
- Macro: RV_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE → TRAP.
  - TRAP holds all outputs at 0 and stays there until reset.
  - Adds output illegal_instr (1 bit), high only in TRAP.
- Undefined:
  - Unknown opcode → FETCH with no side effects.
  - illegal_instr port is absent.

Test Plan:
- add x3,x1,x2 (opcode 0110011, f3 000, f7 0): mem_ready tied 1 → FETCH, DECODE, EXEC_R, ALUWB; alu_control = 0 in EXEC_R; reg_write only in cycle 4; instr_retire once.
- sub (f7 0100000) → alu_control = 1; srai (0010011, f3 101, f7 0100000) → 8; addi with f7 = 0100000 → 0.
- lw with mem_ready low for 3 cycles in MEMRD → mem_req and adr_src = 1 held 3 cycles; MEMWB reg_write = 1, result_src = 1; total 8 cycles.
- sw, mem_ready asserted on first MEMWR cycle → mem_we = 1 for exactly one cycle; reg_write never 1.
- bne with alu_zero = 0 → pc_write = 1 in BRANCH; beq with alu_zero = 0 → pc_write = 0; bltu with alu_ltu = 1 → pc_write = 1.
- rst_n low during MEMWR with mem_ready = 1 → no write completes; next cycle is FETCH with all outputs 0 during reset. With RV_CTRL_ILLEGAL_TRAP_EN, opcode 1111111 → illegal_instr = 1, stuck until reset.
